inst_fetch_unit: RTL and testbench

- IF stage and IF/ID register of the 5-stage MIPS core on the SRAM interface.
- Generates the PC and drives the synchronous instruction SRAM.
- Keeps the returned word aligned with its PC across stalls, redirects and flushes.
- Delivers instrD/pcD to the decode stage, where the instruction decoder consumes instrD.

---
 rtl/inst_fetch_unit_if.sv | 19 +
 rtl/inst_fetch_unit.sv | 117 +++++++++++
 tb/tb_inst_fetch_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// Instruction SRAM port between the fetch unit (master) and the synchronous
// instruction memory (slave); read data arrives one cycle after the address.
interface inst_fetch_unit_if;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_en,
        output inst_sram_addr,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_addr,
        output inst_sram_rdata
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// IF stage and IF/ID pipeline register: PC generation, SRAM fetch and
// alignment of the returned word with its PC across stalls, redirects and flushes.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      stallF,
    input  logic                      stallD,
    input  logic                      flushD,
    input  logic                      branch_takenD,
    input  logic [31:0]               branch_targetD,
    input  logic                      jumpD,
    input  logic [31:0]               jump_targetD,
    input  logic                      exc_flush,
    input  logic [31:0]               exc_pc,
    inst_fetch_unit_if.master         sram,
    output logic [31:0]               pcF,
    output logic [31:0]               instrD,
    output logic [31:0]               pcD,
    output logic                      validD,
    output logic                      adelD
);

    localparam int unsigned XLEN = 32;

    // Priming: the first post-reset cycle only issues the reset-PC read.
    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   pcd_q, pcd_d;
    logic              valid_q, valid_d;
    logic              adel_q, adel_d;
    logic              primed;

    assign primed = (state_q == ST_RUN);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_PRIME;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcd_q   <= '0;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            valid_q <= valid_d;
            adel_q  <= adel_d;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        pc_d    = pc_q + XLEN'(4);
        instr_d = instr_q;
        pcd_d   = pcd_q;
        valid_d = valid_q;
        adel_d  = adel_q;

        // Next PC; a stalled F drops any D redirect, D re-presents it later.
        if (exc_flush) begin
            pc_d = exc_pc;
        end else if (stallF || !primed) begin
            pc_d = pc_q;
        end else if (jumpD) begin
            pc_d = jump_targetD;
        end else if (branch_takenD) begin
            pc_d = branch_targetD;
        end

        // IF/ID register; the word in F after a redirect is the delay slot.
        if (flushD || exc_flush) begin
            instr_d = NOP_INSTR;
            pcd_d   = pc_q;
            valid_d = 1'b0;
            adel_d  = 1'b0;
        end else if (stallD) begin
            instr_d = instr_q;
        end else if (!primed) begin
            instr_d = NOP_INSTR;
            pcd_d   = pc_q;
            valid_d = 1'b0;
            adel_d  = 1'b0;
        end else if (pc_q[1:0] != 2'b00) begin
            instr_d = NOP_INSTR;
            pcd_d   = pc_q;
            valid_d = 1'b1;
            adel_d  = 1'b1;
        end else begin
            instr_d = sram.inst_sram_rdata;
            pcd_d   = pc_q;
            valid_d = 1'b1;
            adel_d  = 1'b0;
        end
    end

    // Address is the next PC so the SRAM word lines up with pcF one cycle later.
    assign sram.inst_sram_addr = pc_d;
    assign sram.inst_sram_en   = (pc_d[1:0] == 2'b00);

    assign pcF    = pc_q;
    assign instrD = instr_q;
    assign pcD    = pcd_q;
    assign validD = valid_q;
    assign adelD  = adel_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: SRAM returns word == address, expected
// F/D state per cycle is queued and checked after each rising edge.
module tb_inst_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic        valid;
        logic        adel;
        logic        chk_pcd;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0;
    logic        branch_takenD = 1'b0, jumpD = 1'b0, exc_flush = 1'b0;
    logic [31:0] branch_targetD = '0, jump_targetD = '0, exc_pc = '0;
    logic [31:0] pcF, instrD, pcD;
    logic        validD, adelD;

    int n_cmp  = 0;
    int n_fail = 0;
    exp_t sb[$];

    inst_fetch_unit_if sram_if ();

    inst_fetch_unit dut (
        .clk            (clk),
        .resetn         (resetn),
        .stallF         (stallF),
        .stallD         (stallD),
        .flushD         (flushD),
        .branch_takenD  (branch_takenD),
        .branch_targetD (branch_targetD),
        .jumpD          (jumpD),
        .jump_targetD   (jump_targetD),
        .exc_flush      (exc_flush),
        .exc_pc         (exc_pc),
        .sram           (sram_if.master),
        .pcF            (pcF),
        .instrD         (instrD),
        .pcD            (pcD),
        .validD         (validD),
        .adelD          (adelD)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: one-cycle latency, each word equals its address.
    always_ff @(posedge clk) begin
        if (sram_if.inst_sram_en) sram_if.inst_sram_rdata <= sram_if.inst_sram_addr;
    end

    task automatic cmp32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] pcd, input logic valid,
                                input logic adel, input logic chk_pcd);
        exp_t e;
        e.pc = pc; e.instr = instr; e.pcd = pcd;
        e.valid = valid; e.adel = adel; e.chk_pcd = chk_pcd;
        return e;
    endfunction

    // Push the expectation for the coming edge, then pop and compare after it.
    task automatic tick(input exp_t e);
        exp_t got;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        cmp32("pcF", pcF, got.pc);
        cmp32("instrD", instrD, got.instr);
        if (got.chk_pcd) cmp32("pcD", pcD, got.pcd);
        cmp32("validD", 32'(validD), 32'(got.valid));
        cmp32("adelD", 32'(adelD), 32'(got.adel));
    endtask

    task automatic chk_bus(input logic en, input logic [31:0] addr);
        #1;
        cmp32("sram_en", 32'(sram_if.inst_sram_en), 32'(en));
        cmp32("sram_addr", sram_if.inst_sram_addr, addr);
    endtask

    task automatic chk_reset();
        cmp32("rst_pcF", pcF, 32'hBFC0_0000);
        cmp32("rst_instrD", instrD, 32'h0);
        cmp32("rst_pcD", pcD, 32'h0);
        cmp32("rst_validD", 32'(validD), 32'h0);
        cmp32("rst_adelD", 32'(adelD), 32'h0);
        cmp32("rst_sram_en", 32'(sram_if.inst_sram_en), 32'h1);
        cmp32("rst_sram_addr", sram_if.inst_sram_addr, 32'hBFC0_0000);
    endtask

    initial begin
        #12;
        chk_reset();
        resetn = 1'b1;

        // Priming then free-run.
        tick(mk(32'hBFC0_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        chk_bus(1'b1, 32'hBFC0_0004);
        tick(mk(32'hBFC0_0004, 32'hBFC0_0000, 32'hBFC0_0000, 1'b1, 1'b0, 1'b1));
        tick(mk(32'hBFC0_0008, 32'hBFC0_0004, 32'hBFC0_0004, 1'b1, 1'b0, 1'b1));
        tick(mk(32'hBFC0_000C, 32'hBFC0_0008, 32'hBFC0_0008, 1'b1, 1'b0, 1'b1));

        // Taken branch with BFC0000C as delay slot.
        branch_takenD = 1'b1; branch_targetD = 32'hBFC0_0100;
        chk_bus(1'b1, 32'hBFC0_0100);
        tick(mk(32'hBFC0_0100, 32'hBFC0_000C, 32'hBFC0_000C, 1'b1, 1'b0, 1'b1));
        branch_takenD = 1'b0;
        tick(mk(32'hBFC0_0104, 32'hBFC0_0100, 32'hBFC0_0100, 1'b1, 1'b0, 1'b1));

        // Three-cycle full stall.
        stallF = 1'b1; stallD = 1'b1;
        chk_bus(1'b1, 32'hBFC0_0104);
        for (int i = 0; i < 3; i++)
            tick(mk(32'hBFC0_0104, 32'hBFC0_0100, 32'hBFC0_0100, 1'b1, 1'b0, 1'b1));
        stallF = 1'b0; stallD = 1'b0;
        tick(mk(32'hBFC0_0108, 32'hBFC0_0104, 32'hBFC0_0104, 1'b1, 1'b0, 1'b1));
        tick(mk(32'hBFC0_010C, 32'hBFC0_0108, 32'hBFC0_0108, 1'b1, 1'b0, 1'b1));

        // Jump beats branch; exception beats both.
        jumpD = 1'b1; jump_targetD = 32'h8000_0000;
        branch_takenD = 1'b1; branch_targetD = 32'h9000_0000;
        chk_bus(1'b1, 32'h8000_0000);
        tick(mk(32'h8000_0000, 32'hBFC0_010C, 32'hBFC0_010C, 1'b1, 1'b0, 1'b1));
        exc_flush = 1'b1; exc_pc = 32'hBFC0_0380;
        chk_bus(1'b1, 32'hBFC0_0380);
        tick(mk(32'hBFC0_0380, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b1));
        jumpD = 1'b0; branch_takenD = 1'b0; exc_flush = 1'b0;
        tick(mk(32'hBFC0_0384, 32'hBFC0_0380, 32'hBFC0_0380, 1'b1, 1'b0, 1'b1));

        // Misaligned jump target.
        jumpD = 1'b1; jump_targetD = 32'h8000_0002;
        chk_bus(1'b0, 32'h8000_0002);
        tick(mk(32'h8000_0002, 32'hBFC0_0384, 32'hBFC0_0384, 1'b1, 1'b0, 1'b1));
        jumpD = 1'b0;
        chk_bus(1'b0, 32'h8000_0006);
        tick(mk(32'h8000_0006, 32'h0, 32'h8000_0002, 1'b1, 1'b1, 1'b1));
        jumpD = 1'b1; jump_targetD = 32'hBFC0_0040;
        tick(mk(32'hBFC0_0040, 32'h0, 32'h8000_0006, 1'b1, 1'b1, 1'b1));
        jumpD = 1'b0;

        // Asynchronous reset mid-stream, then priming repeats.
        #1 resetn = 1'b0;
        #1 chk_reset();
        resetn = 1'b1;
        tick(mk(32'hBFC0_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        tick(mk(32'hBFC0_0004, 32'hBFC0_0000, 32'hBFC0_0000, 1'b1, 1'b0, 1'b1));

        // PC wrap at the top of the address space.
        jumpD = 1'b1; jump_targetD = 32'hFFFF_FFFC;
        tick(mk(32'hFFFF_FFFC, 32'hBFC0_0004, 32'hBFC0_0004, 1'b1, 1'b0, 1'b1));
        jumpD = 1'b0;
        chk_bus(1'b1, 32'h0000_0000);
        tick(mk(32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1));
        tick(mk(32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1));

        // flushD alone, then exception overriding stallF.
        flushD = 1'b1;
        tick(mk(32'h0000_0008, 32'h0, 32'h0000_0004, 1'b0, 1'b0, 1'b1));
        flushD = 1'b0;
        stallF = 1'b1; exc_flush = 1'b1; exc_pc = 32'hBFC0_0380;
        chk_bus(1'b1, 32'hBFC0_0380);
        tick(mk(32'hBFC0_0380, 32'h0, 32'h0000_0008, 1'b0, 1'b0, 1'b1));
        stallF = 1'b0; exc_flush = 1'b0;
        tick(mk(32'hBFC0_0384, 32'hBFC0_0380, 32'hBFC0_0380, 1'b1, 1'b0, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
